// File: rtl/irq_generator_pkg.sv
// Shared definitions for the interrupt generator: per-line FSM encoding,
// line numbering and the mapping from line number to event/irq bit.
package irq_generator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FIRE     = 2'd1,
    ST_WAIT_ACK = 2'd2
  } line_state_e;

  localparam int NUM_LINES = 3;

  localparam logic [1:0] LINE1 = 2'd1;
  localparam logic [1:0] LINE2 = 2'd2;
  localparam logic [1:0] LINE3 = 2'd3;

  // Out of reset every line is suppressed until software opens the mask.
  localparam logic [NUM_LINES-1:0] MASK_RESET = 3'b111;

  // Line 1 is the MSB of every per-line vector, line 3 the LSB.
  function automatic int line_bit(input logic [1:0] line);
    return NUM_LINES - int'(line);
  endfunction

endpackage

// File: rtl/irq_generator_if.sv
// Bus between the CPU/device side and the interrupt generator.
interface irq_generator_if
  import irq_generator_pkg::*;
#(
  parameter int TIMER_W = 16
) ();

  logic [NUM_LINES-1:0] dev_event;
  logic                 mask_we;
  logic [NUM_LINES-1:0] mask_in;
  logic                 timer_en;
  logic [TIMER_W-1:0]   timer_period;
  logic                 ack;
  logic [1:0]           ack_line;
  logic [NUM_LINES-1:0] irq;
  logic [NUM_LINES-1:0] in_service;
  logic [NUM_LINES-1:0] pending;
  logic [NUM_LINES-1:0] lost;

  modport master (
    output dev_event, mask_we, mask_in, timer_en, timer_period, ack, ack_line,
    input  irq, in_service, pending, lost
  );

  modport slave (
    input  dev_event, mask_we, mask_in, timer_en, timer_period, ack, ack_line,
    output irq, in_service, pending, lost
  );

endinterface

// File: rtl/irq_generator_line.sv
// One interrupt line: saturating pending-event counter plus the
// IDLE -> FIRE -> WAIT_ACK handshake FSM that produces a one-cycle irq pulse.
module irq_line
  import irq_generator_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic event_in,
  input  logic masked,
  input  logic ack_hit,
  output logic irq,
  output logic in_service,
  output logic pending,
  output logic lost
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  line_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_q, irq_d;
  logic             in_service_q, in_service_d;
  logic             lost_q, lost_d;
  logic             fire;

  // Next state of the handshake FSM; irq and in_service are registered alongside it.
  always_comb begin
    state_d      = state_q;
    irq_d        = 1'b0;
    in_service_d = in_service_q;
    fire         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cnt_q != '0 && !masked) begin
          fire         = 1'b1;
          state_d      = ST_FIRE;
          irq_d        = 1'b1;
          in_service_d = 1'b1;
        end
      end
      ST_FIRE: begin
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (ack_hit) begin
          state_d      = ST_IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        in_service_d = 1'b0;
      end
    endcase
  end

  // Pending counter: an event and a fire in the same cycle cancel out.
  always_comb begin
    cnt_d  = cnt_q;
    lost_d = lost_q;
    if (event_in && !fire) begin
      if (cnt_q == CNT_MAX) begin
        lost_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (!event_in && fire) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Line state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      irq_q        <= 1'b0;
      in_service_q <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      irq_q        <= irq_d;
      in_service_q <= in_service_d;
      lost_q       <= lost_d;
    end
  end

  assign irq        = irq_q;
  assign in_service = in_service_q;
  assign pending    = (cnt_q != '0);
  assign lost       = lost_q;

endmodule

// File: rtl/irq_generator.sv
// Interrupt generator top: mask register, periodic timer feeding line 3,
// and three independent irq_line instances.
module irq_generator
  import irq_generator_pkg::*;
#(
  parameter int TIMER_W = 16,
  parameter int CNT_W   = 2
) (
  input  logic           clk,
  input  logic           rst,
  irq_generator_if.slave bus
);

  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

  logic [NUM_LINES-1:0] mask_q, mask_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 timer_evt;
  logic [NUM_LINES-1:0] line_event;

  // Mask register; a write is seen by the lines from the following cycle.
  always_comb begin
    mask_d = mask_q;
    if (bus.mask_we) begin
      mask_d = bus.mask_in;
    end
  end

  // Down counter; zero means "not yet loaded", reaching one reloads and fires an event.
  always_comb begin
    timer_d   = timer_q;
    timer_evt = 1'b0;
    if (!bus.timer_en || bus.timer_period == '0) begin
      timer_d = bus.timer_period;
    end else if (timer_q == '0) begin
      timer_d = bus.timer_period;
    end else if (timer_q == TIMER_ONE) begin
      timer_d   = bus.timer_period;
      timer_evt = 1'b1;
    end else begin
      timer_d = timer_q - TIMER_ONE;
    end
  end

  // Timer tick and device strobe on line 3 merge into a single event.
  always_comb begin
    line_event                  = bus.dev_event;
    line_event[line_bit(LINE3)] = bus.dev_event[line_bit(LINE3)] | timer_evt;
  end

  // Mask and timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q  <= MASK_RESET;
      timer_q <= '0;
    end else begin
      mask_q  <= mask_d;
      timer_q <= timer_d;
    end
  end

  for (genvar g = 1; g <= NUM_LINES; g++) begin : g_line
    localparam logic [1:0] LINE_ID = 2'(g);
    localparam int         B       = line_bit(LINE_ID);

    irq_line #(.CNT_W(CNT_W)) u_line (
      .clk        (clk),
      .rst        (rst),
      .event_in   (line_event[B]),
      .masked     (mask_q[B]),
      .ack_hit    (bus.ack && (bus.ack_line == LINE_ID)),
      .irq        (bus.irq[B]),
      .in_service (bus.in_service[B]),
      .pending    (bus.pending[B]),
      .lost       (bus.lost[B])
    );
  end

endmodule

// File: doc/irq_generator.md
IRQ_GENERATOR -- requirements
Module: irq_generator

Interface
REQ-001 Parameter TIMER_W, default 16, width of the periodic timer counter and period input.
REQ-002 Parameter CNT_W, default 2, width of each line's saturating pending-event counter.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 dev_event  input  3  one-cycle device event strobes; bit2=line1 (highest priority), bit1=line2, bit0=line3.
REQ-006 mask_we  input  1  write strobe for the mask register.
REQ-007 mask_in  input  3  new mask value; bit set = line suppressed; same bit order as dev_event.
REQ-008 timer_en  input  1  enables the periodic timer.
REQ-009 timer_period  input  TIMER_W  timer reload value, in cycles.
REQ-010 ack  input  1  one-cycle CPU acknowledge (handler finished).
REQ-011 ack_line  input  2  line being acknowledged: 1, 2 or 3; value 0 ignored.
REQ-012 irq  output  3  interrupt pulses to the CPU interrupt inputs; same bit order as dev_event.
REQ-013 in_service  output  3  per line, 1 from its pulse until its acknowledge.
REQ-014 pending  output  3  per line, event counter nonzero.
REQ-015 lost  output  3  sticky per line, an event was dropped at counter saturation.

Function
REQ-016 Each line SHALL run an FSM with states IDLE, FIRE, WAIT_ACK.
REQ-017 IDLE->FIRE when counter>0 and mask bit clear; the counter SHALL decrement by 1 on this transition.
REQ-018 FIRE SHALL last exactly one cycle, with irq bit registered high only in FIRE; FIRE->WAIT_ACK unconditionally.
REQ-019 WAIT_ACK->IDLE on ack with matching ack_line; ack for a line not in WAIT_ACK SHALL be ignored.
REQ-020 Event-to-irq latency SHALL be 2 cycles: strobe at edge N, counter updated at N, FIRE registered at N+1, irq high during the cycle after N+1.
REQ-021 Each event strobe SHALL increment the counter; at 2^CNT_W-1 the counter SHALL hold and lost SHALL set.
REQ-022 Event and IDLE->FIRE decrement in the same cycle SHALL leave the counter unchanged.
REQ-023 Lines SHALL be independent; several irq bits may pulse in the same cycle (the CPU prioritises).
REQ-024 Masking SHALL gate only IDLE->FIRE; a line in FIRE or WAIT_ACK completes normally; masked events still count.
REQ-025 Mask writes SHALL take effect from the cycle after mask_we.
REQ-026 Timer: with timer_en=1 and timer_period>0, a down counter SHALL load timer_period, decrement each cycle, and on reaching 1 reload and strobe a line-3 event, giving one event every timer_period cycles.
REQ-027 timer_period=0 or timer_en=0 SHALL hold the timer loaded with timer_period and generate no events.
REQ-028 A timer event and dev_event[0] in the same cycle SHALL count as one event.
REQ-029 lost SHALL clear only on reset.

Reset
REQ-030 Asserting rst SHALL force all FSMs to IDLE, counters to 0, mask to 3'b111 (all suppressed), timer counter to 0, and irq, in_service, pending and lost to 0, with no clock required.
REQ-031 Reset mid-pulse SHALL drop irq immediately; no pulse SHALL resume after reset release.
REQ-032 The first timer load SHALL occur on the first edge after release with timer_en=1.

Structure
REQ-033 The shared package SHALL hold the FSM state encoding, line index constants (LINE1=1, LINE2=2, LINE3=3), and the irq bit mapping.
REQ-034 Per-line FSM plus counter SHALL be a sub-module irq_line, instantiated three times; the timer and mask register stay in irq_generator.

Verification
REQ-035 Reset, mask=0, dev_event=3'b100 for one cycle -> irq=3'b100 for exactly one cycle 2 cycles later; in_service[2]=1 until ack, ack_line=1.
REQ-036 Four line-2 strobes while in WAIT_ACK, CNT_W=2 -> counter saturates at 3, lost[1]=1; after ack, the next pulse fires 2 cycles after ack; exactly 3 more pulses result given prompt acks.
REQ-037 timer_period=5, timer_en=1, mask=0, acking each pulse -> irq[0] pulses every 5 cycles; period 0 -> no pulses.
REQ-038 Mask=3'b010 with a line-2 event -> no pulse and pending[1]=1; mask cleared -> pulse 1 cycle after the write cycle.
REQ-039 Simultaneous dev_event=3'b111 -> irq=3'b111 in the same cycle; ack with ack_line=0 -> no state change.
REQ-040 rst asserted during FIRE -> irq=0 immediately, all outputs 0; after release no pulse without new events.
